// File: rtl/wbuff_pkg.sv
// Shared constants and load-FSM state encoding for the weight-buffer bank controller.
package wbuff_pkg;

    localparam int NB_TAPS_DEF      = 11;
    localparam int BUFFER_DEPTH_DEF = 72;
    localparam int BUFFER_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } load_state_e;

endpackage

// File: rtl/wbuff_bank_ctrl_if.sv
// Bus bundle between the weight-buffer bank controller and its write source,
// load requester and SRAM bank.
interface wbuff_bank_ctrl_if
    import wbuff_pkg::*;
#(
    parameter int NB_TAPS      = NB_TAPS_DEF,
    parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF,
    parameter int BUFFER_WIDTH = BUFFER_WIDTH_DEF,
    parameter int ADDR_W       = $clog2(BUFFER_DEPTH),
    parameter int TAPS_W       = $clog2(NB_TAPS + 1)
);

    // Write handshake: a word transfers on a rising clk edge where wr_valid and
    // wr_ready are both high; wr_data must be stable while wr_valid is high.
    logic                    wr_valid;
    logic                    wr_ready;
    logic [BUFFER_WIDTH-1:0] wr_data;
    logic                    wr_ptr_clr;

    logic [ADDR_W-1:0]       wAddr;
    logic [BUFFER_WIDTH-1:0] buffer_data_in;
    logic                    buffer_wEn;

    logic                    load_start;
    logic [ADDR_W-1:0]       load_base;
    logic [TAPS_W-1:0]       load_taps;
    logic                    load_clear;

    logic [ADDR_W-1:0]       rAddr;
    logic                    buffer_rEn;
    logic [NB_TAPS-1:0]      weight_load_en;
    logic                    clear_all_wregs;
    logic                    load_busy;
    logic                    load_done;
    load_state_e             dbg_state;

    modport slave (
        input  wr_valid, wr_data, wr_ptr_clr,
        input  load_start, load_base, load_taps, load_clear,
        output wr_ready, wAddr, buffer_data_in, buffer_wEn,
        output rAddr, buffer_rEn, weight_load_en, clear_all_wregs,
        output load_busy, load_done, dbg_state
    );

    modport master (
        output wr_valid, wr_data, wr_ptr_clr,
        output load_start, load_base, load_taps, load_clear,
        input  wr_ready, wAddr, buffer_data_in, buffer_wEn,
        input  rAddr, buffer_rEn, weight_load_en, clear_all_wregs,
        input  load_busy, load_done, dbg_state
    );

endinterface

// File: rtl/wbuff_addr_wrap.sv
// Modular address adder: (a + b) mod DEPTH for operands already below DEPTH,
// using one extra sum bit and a single conditional subtract.
module wbuff_addr_wrap #(
    parameter int DEPTH  = 72,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    output logic [ADDR_W-1:0] sum
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W:0] raw;
    logic [ADDR_W:0] diff;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b};
        diff = raw - DEPTH_W;
        sum  = (raw >= DEPTH_W) ? diff[ADDR_W-1:0] : raw[ADDR_W-1:0];
    end

endmodule

// File: rtl/wbuff_bank_ctrl.sv
// Weight-buffer bank controller: streams incoming weight words into a circular
// SRAM bank and replays a run of words into one-hot selected tap registers.
module wbuff_bank_ctrl
    import wbuff_pkg::*;
#(
    parameter int NB_TAPS      = NB_TAPS_DEF,
    parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF,
    parameter int BUFFER_WIDTH = BUFFER_WIDTH_DEF,
    parameter int ADDR_W       = $clog2(BUFFER_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    wbuff_bank_ctrl_if.slave  bus
);

    localparam int                 TAPS_W    = $clog2(NB_TAPS + 1);
    localparam logic [TAPS_W-1:0]  NB_TAPS_W = TAPS_W'(NB_TAPS);
    localparam logic [NB_TAPS-1:0] TAP0      = NB_TAPS'(1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);

    // Write path state
    logic                    wr_ready_q, wr_ready_d;
    logic                    wr_en_n_q, wr_en_n_d;
    logic [ADDR_W-1:0]       waddr_q, waddr_d;
    logic [BUFFER_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       wr_ptr_inc;
    logic                    accept;

    // Load path state
    load_state_e             state_q, state_d;
    logic                    rd_en_n_q, rd_en_n_d;
    logic [ADDR_W-1:0]       raddr_q, raddr_d;
    logic [TAPS_W-1:0]       rd_idx_q, rd_idx_d;
    logic [TAPS_W-1:0]       n_taps_q, n_taps_d;
    logic [NB_TAPS-1:0]      load_en_q, load_en_d;
    logic                    clear_q, clear_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ADDR_W-1:0]       rd_op_a, rd_op_b, rd_next;
    logic [TAPS_W-1:0]       taps_eff;

    wbuff_addr_wrap #(.DEPTH(BUFFER_DEPTH), .ADDR_W(ADDR_W)) u_wr_wrap (
        .a   (wr_ptr_q),
        .b   (ADDR_ONE),
        .sum (wr_ptr_inc)
    );

    // In IDLE the read adder folds load_base into range; in READ it steps by one.
    assign rd_op_a = (state_q == ST_IDLE) ? bus.load_base : raddr_q;
    assign rd_op_b = (state_q == ST_IDLE) ? '0 : ADDR_ONE;

    wbuff_addr_wrap #(.DEPTH(BUFFER_DEPTH), .ADDR_W(ADDR_W)) u_rd_wrap (
        .a   (rd_op_a),
        .b   (rd_op_b),
        .sum (rd_next)
    );

    assign taps_eff = (bus.load_taps > NB_TAPS_W) ? NB_TAPS_W : bus.load_taps;

    always_comb begin
        wr_ready_d = 1'b1;
        accept     = bus.wr_valid & wr_ready_q;
        wr_en_n_d  = ~accept;
        waddr_d    = accept ? wr_ptr_q : waddr_q;
        wdata_d    = accept ? bus.wr_data : wdata_q;
        if (bus.wr_ptr_clr) begin
            wr_ptr_d = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_inc;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_en_n_d = 1'b1;
        raddr_d   = raddr_q;
        rd_idx_d  = rd_idx_q;
        n_taps_d  = n_taps_q;
        load_en_d = '0;
        clear_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    clear_d = bus.load_clear;
                    if (taps_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ST_READ;
                        rd_en_n_d = 1'b0;
                        raddr_d   = rd_next;
                        rd_idx_d  = '0;
                        n_taps_d  = taps_eff;
                        busy_d    = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // The tap enable trails its read by one cycle to meet SRAM read data.
                load_en_d = TAP0 << rd_idx_q;
                if (rd_idx_q == n_taps_q - TAPS_W'(1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_en_n_d = 1'b0;
                    raddr_d   = rd_next;
                    rd_idx_d  = rd_idx_q + TAPS_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ready_q <= 1'b0;
            wr_en_n_q  <= 1'b1;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wr_ptr_q   <= '0;
            state_q    <= ST_IDLE;
            rd_en_n_q  <= 1'b1;
            raddr_q    <= '0;
            rd_idx_q   <= '0;
            n_taps_q   <= '0;
            load_en_q  <= '0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ready_q <= wr_ready_d;
            wr_en_n_q  <= wr_en_n_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wr_ptr_q   <= wr_ptr_d;
            state_q    <= state_d;
            rd_en_n_q  <= rd_en_n_d;
            raddr_q    <= raddr_d;
            rd_idx_q   <= rd_idx_d;
            n_taps_q   <= n_taps_d;
            load_en_q  <= load_en_d;
            clear_q    <= clear_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.wr_ready        = wr_ready_q;
    assign bus.buffer_wEn      = wr_en_n_q;
    assign bus.wAddr           = waddr_q;
    assign bus.buffer_data_in  = wdata_q;
    assign bus.buffer_rEn      = rd_en_n_q;
    assign bus.rAddr           = raddr_q;
    assign bus.weight_load_en  = load_en_q;
    assign bus.clear_all_wregs = clear_q;
    assign bus.load_busy       = busy_q;
    assign bus.load_done       = done_q;
    assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_wbuff_bank_ctrl.sv
// Self-checking bench for wbuff_bank_ctrl: directed load/write scenarios with
// queue-based scoreboards for SRAM writes, SRAM reads and tap enables.
module tb_wbuff_bank_ctrl;
    import wbuff_pkg::*;

    localparam int NB    = 11;
    localparam int DEPTH = 72;
    localparam int W     = 16;
    localparam int AW    = 7;
    localparam int TW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wbuff_bank_ctrl_if #(.NB_TAPS(NB), .BUFFER_DEPTH(DEPTH), .BUFFER_WIDTH(W)) bus ();

    wbuff_bank_ctrl #(.NB_TAPS(NB), .BUFFER_DEPTH(DEPTH), .BUFFER_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    int done_cnt = 0;
    int clr_cnt = 0;
    int exp_ptr = 0;
    bit mon_en  = 1'b0;

    logic [AW+W-1:0] exp_wr_q[$];
    logic [AW-1:0]   exp_rd_q[$];
    logic [NB-1:0]   exp_le_q[$];
    logic [AW+W-1:0] e_wr;
    logic [AW-1:0]   e_rd;
    logic [NB-1:0]   e_le;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [W-1:0] d, input logic clr);
        bus.wr_valid   = 1'b1;
        bus.wr_data    = d;
        bus.wr_ptr_clr = clr;
        exp_wr_q.push_back({AW'(exp_ptr), d});
        exp_ptr = clr ? 0 : ((exp_ptr == DEPTH - 1) ? 0 : exp_ptr + 1);
        tick();
        bus.wr_valid   = 1'b0;
        bus.wr_ptr_clr = 1'b0;
        check("wr_en_low", 32'(bus.buffer_wEn), 32'd0);
    endtask

    // Drives load_start for one cycle; returns in cycle S+1.
    task automatic start_load(input int base, input int taps, input logic clr,
                              input int n_rd, input int n_le);
        for (int k = 0; k < n_rd; k++) exp_rd_q.push_back(AW'((base + k) % DEPTH));
        for (int k = 0; k < n_le; k++) exp_le_q.push_back(NB'(1) << k);
        bus.load_start = 1'b1;
        bus.load_base  = AW'(base);
        bus.load_taps  = TW'(taps);
        bus.load_clear = clr;
        tick();
        bus.load_start = 1'b0;
        bus.load_clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.buffer_wEn === 1'b0) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e_wr = exp_wr_q.pop_front();
                    check("wAddr", 32'(bus.wAddr), 32'(e_wr[AW+W-1:W]));
                    check("wdata", 32'(bus.buffer_data_in), 32'(e_wr[W-1:0]));
                end
            end
            if (bus.buffer_rEn === 1'b0) begin
                rd_cnt++;
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e_rd = exp_rd_q.pop_front();
                    check("rAddr", 32'(bus.rAddr), 32'(e_rd));
                end
            end
            if (bus.weight_load_en !== '0) begin
                if (exp_le_q.size() == 0) begin
                    check("le_unexpected", 32'(bus.weight_load_en), 32'd0);
                end else begin
                    e_le = exp_le_q.pop_front();
                    check("load_en", 32'(bus.weight_load_en), 32'(e_le));
                end
            end
            if (bus.load_done === 1'b1) done_cnt++;
            if (bus.clear_all_wregs === 1'b1) clr_cnt++;
        end
    end

    initial begin
        int d0, r0;
        rst = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_ptr_clr = 1'b0;
        bus.load_start = 1'b0; bus.load_base = '0; bus.load_taps = '0; bus.load_clear = 1'b0;
        repeat (2) tick();
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_wEn", 32'(bus.buffer_wEn), 32'd1);
        check("rst_rEn", 32'(bus.buffer_rEn), 32'd1);
        check("rst_wAddr", 32'(bus.wAddr), 32'd0);
        check("rst_rAddr", 32'(bus.rAddr), 32'd0);
        check("rst_data", 32'(bus.buffer_data_in), 32'd0);
        check("rst_le", 32'(bus.weight_load_en), 32'd0);
        check("rst_clear", 32'(bus.clear_all_wregs), 32'd0);
        check("rst_busy", 32'(bus.load_busy), 32'd0);
        check("rst_done", 32'(bus.load_done), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();
        check("wr_ready_up", 32'(bus.wr_ready), 32'd1);
        mon_en = 1'b1;

        // base 70, 4 taps, clear: cycle-exact timeline over S+1..S+7
        start_load(70, 4, 1'b1, 4, 4);
        check("state_read", 32'(bus.dbg_state), 32'(ST_READ));
        for (int c = 1; c <= 7; c++) begin
            check("t_busy", 32'(bus.load_busy), (c <= 5) ? 32'd1 : 32'd0);
            check("t_done", 32'(bus.load_done), (c == 6) ? 32'd1 : 32'd0);
            check("t_rEn", 32'(bus.buffer_rEn), (c <= 4) ? 32'd0 : 32'd1);
            check("t_clear", 32'(bus.clear_all_wregs), (c == 1) ? 32'd1 : 32'd0);
            check("t_le", 32'(bus.weight_load_en),
                  (c >= 2 && c <= 5) ? (32'd1 << (c - 2)) : 32'd0);
            if (c < 7) tick();
        end

        // 11 taps with a second load_start in S+3 that must be ignored
        d0 = done_cnt; r0 = rd_cnt;
        start_load(5, 11, 1'b0, 11, 11);
        tick(); tick();
        bus.load_start = 1'b1; bus.load_base = AW'(0); bus.load_taps = TW'(2);
        tick();
        bus.load_start = 1'b0;
        repeat (12) tick();
        check("retrig_reads", 32'(rd_cnt - r0), 32'd11);
        check("retrig_done", 32'(done_cnt - d0), 32'd1);

        // tap count above NB_TAPS clamps to NB_TAPS
        r0 = rd_cnt;
        start_load(10, 15, 1'b0, 11, 11);
        repeat (14) tick();
        check("clamp_reads", 32'(rd_cnt - r0), 32'd11);

        // new start accepted in the load_done cycle
        start_load(30, 1, 1'b0, 1, 1);
        tick(); tick();
        check("b2b_done", 32'(bus.load_done), 32'd1);
        start_load(40, 2, 1'b0, 2, 2);
        check("b2b_busy", 32'(bus.load_busy), 32'd1);
        check("b2b_rAddr", 32'(bus.rAddr), 32'd40);
        repeat (5) tick();

        // zero taps: immediate done, no reads
        start_load(0, 0, 1'b0, 0, 0);
        check("z_done", 32'(bus.load_done), 32'd1);
        check("z_rEn", 32'(bus.buffer_rEn), 32'd1);
        check("z_busy", 32'(bus.load_busy), 32'd0);
        tick();
        check("z_done_off", 32'(bus.load_done), 32'd0);

        // reset in S+3 of an 11-tap load aborts it
        d0 = done_cnt;
        start_load(12, 11, 1'b0, 3, 2);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("abort_le", 32'(bus.weight_load_en), 32'd0);
        check("abort_rEn", 32'(bus.buffer_rEn), 32'd1);
        check("abort_busy", 32'(bus.load_busy), 32'd0);
        check("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        exp_ptr = 0;
        repeat (14) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_rd_q", 32'(exp_rd_q.size()), 32'd0);
        check("abort_le_q", 32'(exp_le_q.size()), 32'd0);

        // writes from reset: 0x1111, 0x2222, 0x3333 at 0,1,2
        wr_word(16'h1111, 1'b0);
        wr_word(16'h2222, 1'b0);
        wr_word(16'h3333, 1'b0);
        tick();
        check("wr_idle", 32'(bus.buffer_wEn), 32'd1);

        bus.wr_ptr_clr = 1'b1;
        tick();
        bus.wr_ptr_clr = 1'b0;
        exp_ptr = 0;
        check("clr_no_write", 32'(bus.buffer_wEn), 32'd1);

        // 73 words: the last wraps to address 0
        for (int i = 0; i < 73; i++) wr_word(W'($urandom_range(0, 16'hffff)), 1'b0);
        check("wrap_addr", 32'(bus.wAddr), 32'd0);
        for (int i = 0; i < 4; i++) wr_word(W'($urandom_range(0, 16'hffff)), 1'b0);
        wr_word(16'hc1c1, 1'b1);
        check("clr_acc_addr", 32'(bus.wAddr), 32'd5);
        wr_word(16'hd2d2, 1'b0);
        check("after_clr_addr", 32'(bus.wAddr), 32'd0);

        // load and write traffic overlapping
        start_load(60, 3, 1'b0, 3, 3);
        wr_word(16'hab01, 1'b0);
        wr_word(16'hab02, 1'b0);
        wr_word(16'hab03, 1'b0);
        repeat (6) tick();

        check("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        check("le_q_empty", 32'(exp_le_q.size()), 32'd0);
        check("clear_count", 32'(clr_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wbuff_bank_ctrl.md
WBUFF_BANK_CTRL -- requirements
Module: wbuff_bank_ctrl

Interface
REQ-001 SHALL have parameter NB_TAPS, default 11, number of weight-register taps driven.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 72, bank SRAM word count.
REQ-003 SHALL have parameter BUFFER_WIDTH, default 16, SRAM word width.
REQ-004 SHALL have parameter ADDR_W, default clog2(BUFFER_DEPTH), address width.
REQ-005 SHALL have ports clk in 1 (sole clock) and rst in 1: one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports wr_valid in 1 (weight word offered), wr_ready out 1 (word accepted when both high), wr_data in BUFFER_WIDTH (weight word).
REQ-007 SHALL have port wr_ptr_clr in 1, which returns the write pointer to 0.
REQ-008 SHALL have ports wAddr out ADDR_W, buffer_data_in out BUFFER_WIDTH and buffer_wEn out 1 (active-low SRAM write enable).
REQ-009 SHALL have ports load_start in 1, load_base in ADDR_W (first read address), load_taps in clog2(NB_TAPS+1) (tap count) and load_clear in 1 (clear taps first).
REQ-010 SHALL have ports rAddr out ADDR_W, buffer_rEn out 1 (active-low SRAM read enable), weight_load_en out NB_TAPS (one-hot tap capture) and clear_all_wregs out 1.
REQ-011 SHALL have ports load_busy out 1 and load_done out 1 (one-cycle pulse).

Function
REQ-012 SHALL register all outputs.
REQ-013 SHALL drive wr_ready high in every non-reset cycle.
REQ-014 SHALL present each accepted word in the next cycle with buffer_wEn=0, wAddr=wr_ptr and buffer_data_in=wr_data; otherwise buffer_wEn=1.
REQ-015 SHALL increment wr_ptr per accepted word, wrapping from BUFFER_DEPTH-1 to 0.
REQ-016 SHALL, when wr_ptr_clr and an accept coincide, write the word at the old wr_ptr and then set wr_ptr to 0; wr_ptr_clr has priority over increment.
REQ-017 SHALL run load FSM states IDLE, READ and DRAIN, with an operation-done condition signalled on the return to IDLE.
REQ-018 SHALL accept load_start only in IDLE and ignore it in any other state.
REQ-019 SHALL, when load_start is sampled in cycle S with N=load_taps in 1..NB_TAPS, enter READ at S+1 and drive buffer_rEn=0 with rAddr=(load_base+k) mod BUFFER_DEPTH in cycle S+1+k, k=0..N-1.
REQ-020 SHALL drive weight_load_en[k] alone high in cycle S+2+k, matching the 1-cycle SRAM read latency.
REQ-021 SHALL enter DRAIN at S+N+1, pulse load_done and return to IDLE at S+N+2, and hold load_busy high over S+1..S+N+1.
REQ-022 SHALL, for load_taps=0, perform no reads and no load enables, and pulse load_done at S+1.
REQ-023 SHALL clamp load_taps>NB_TAPS to NB_TAPS.
REQ-024 SHALL drive clear_all_wregs high in cycle S+1 only when load_clear was sampled with load_start.
REQ-025 SHALL accept a load_start that coincides with load_done.
REQ-026 SHALL compute address wrap with an ADDR_W+1 bit sum and a conditional subtract of BUFFER_DEPTH, with no modulo operator.
REQ-027 SHALL let write and load traffic proceed concurrently and independently, with no arbitration.

Reset
REQ-028 SHALL, while rst is high, force: wr_ready=0, buffer_wEn=1, buffer_rEn=1, wAddr=0, rAddr=0, buffer_data_in=0, weight_load_en=0, clear_all_wregs=0, load_busy=0, load_done=0, wr_ptr=0, state IDLE.
REQ-029 SHALL abort any load in progress on mid-operation reset, with no further enable, read or done pulse.

Structure
REQ-030 SHALL place the FSM state enum and default parameter constants in a shared package wbuff_pkg.
REQ-031 SHALL implement the wrapping address adder as sub-module wbuff_addr_wrap, instantiated for the write and read paths.

Verification
REQ-032 SHALL cover: 3 words 0x1111, 0x2222, 0x3333 from reset -> buffer_wEn low 3 cycles, wAddr 0,1,2 with matching data.
REQ-033 SHALL cover: 73 accepted words -> word 72 written at wAddr 0 (wrap).
REQ-034 SHALL cover: load_start with base=70, taps=4, clear=1 -> clear_all_wregs at S+1; rAddr 70,71,0,1 over S+1..S+4; weight_load_en 0x001,0x002,0x004,0x008 over S+2..S+5; load_done at S+6.
REQ-035 SHALL cover: load_start re-asserted at S+3 of a taps=11 load -> ignored, exactly 11 reads occur.
REQ-036 SHALL cover: rst high at S+3 of a taps=11 load -> weight_load_en=0 and buffer_rEn=1 from the next cycle, no load_done.
REQ-037 SHALL cover: taps=0 -> load_done at S+1, buffer_rEn stays 1; and wr_ptr_clr concurrent with an accept at ptr 5 -> write at 5, next word at 0.
